// File: rtl/jesd204b_dl_rx_mlane.sv
// Multi-lane JESD204B receive data link: per-lane CGS FSM, 1-stage write path into per-lane
// elastic buffers, all lanes released together on LMFC. `JESD_DL_CHAR_REPLACE_EN adds /A/ /F/ replacement.
module jesd204b_dl_rx_mlane #(
    parameter int LANES          = 2,
    parameter int OCTETS_PER_CYC = 4,
    parameter int F              = 5,
    parameter int K              = 4,
    parameter int BUF_DEPTH      = 32
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              lmfc,
    input  logic                              scramble_en,
    input  logic [LANES*8*OCTETS_PER_CYC-1:0] in_data,
    input  logic [LANES*OCTETS_PER_CYC-1:0]   in_charisk,
    input  logic [LANES-1:0]                  in_valid,
    output logic [LANES*8*OCTETS_PER_CYC-1:0] out_data,
    output logic                              out_valid,
    output logic                              sync_n,
    output logic [LANES-1:0]                  buf_err
);
    localparam int W  = 8*OCTETS_PER_CYC;
    localparam int AW = $clog2(BUF_DEPTH);
    localparam int FW = $clog2(F+1);

    localparam logic [1:0] CGS_INIT  = 2'd0;
    localparam logic [1:0] CGS_CHECK = 2'd1;
    localparam logic [1:0] CGS_DATA  = 2'd2;

    logic [1:0]       state_q [LANES];
    logic [1:0]       state_d [LANES];
    logic [1:0]       vcnt_q  [LANES];
    logic [1:0]       vcnt_d  [LANES];
    logic [1:0]       icnt_q  [LANES];
    logic [1:0]       icnt_d  [LANES];
    logic [W-1:0]     proc_dat [LANES];
    logic [W-1:0]     s1_dat_q [LANES];
    logic [AW-1:0]    wr_ptr_q [LANES];
    logic [AW-1:0]    fill     [LANES];
    logic [W-1:0]     mem_q    [LANES][BUF_DEPTH];
    logic [AW-1:0]    rd_ptr_q;
    logic [LANES-1:0] init_d, all_k, start_now, wr_req, full_pre, wr_go;
    logic [LANES-1:0] started_q, s1_wen_q, ovf_q, buf_err_q;
    logic [W*LANES-1:0] out_data_q;
    logic             clear, release_q, out_valid_q, sync_n_q;

    // K only shapes the LMFC period upstream; scramble_en is only consumed by character replacement.
    logic unused_cfg;
    assign unused_cfg = ^{scramble_en, K[0]};

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            state_d[l] = state_q[l];
            vcnt_d[l]  = vcnt_q[l];
            icnt_d[l]  = icnt_q[l];
            all_k[l]   = 1'b1;
            for (int o = 0; o < OCTETS_PER_CYC; o++) begin
                if (!in_charisk[l*OCTETS_PER_CYC+o] ||
                    in_data[(l*OCTETS_PER_CYC+o)*8 +: 8] != 8'hBC)
                    all_k[l] = 1'b0;
            end
            case (state_q[l])
                CGS_INIT: begin
                    vcnt_d[l] = 2'd0;
                    icnt_d[l] = 2'd0;
                    if (in_valid[l] && all_k[l]) state_d[l] = CGS_CHECK;
                end
                CGS_CHECK: begin
                    if (in_valid[l]) begin
                        icnt_d[l] = 2'd0;
                        vcnt_d[l] = (vcnt_q[l] == 2'd3) ? 2'd0 : vcnt_q[l] + 2'd1;
                        if (vcnt_q[l] == 2'd3) state_d[l] = CGS_DATA;
                    end else begin
                        vcnt_d[l] = 2'd0;
                        icnt_d[l] = (icnt_q[l] == 2'd2) ? 2'd0 : icnt_q[l] + 2'd1;
                        if (icnt_q[l] == 2'd2) state_d[l] = CGS_INIT;
                    end
                end
                default: begin
                    // The dropping cycle is the first of the invalid run seen in CGS_CHECK.
                    vcnt_d[l] = 2'd0;
                    icnt_d[l] = in_valid[l] ? 2'd0 : 2'd1;
                    if (!in_valid[l]) state_d[l] = CGS_CHECK;
                end
            endcase
            init_d[l] = (state_d[l] == CGS_INIT);
        end
    end

    always_comb begin
        clear = |init_d;
        for (int l = 0; l < LANES; l++) begin
            start_now[l] = (state_q[l] != CGS_INIT) && !all_k[l] && !started_q[l];
            wr_req[l]    = !clear && (started_q[l] || start_now[l]);
            fill[l]      = wr_ptr_q[l] - rd_ptr_q;
            full_pre[l]  = !release_q && (fill[l] == AW'(BUF_DEPTH-1));
            wr_go[l]     = s1_wen_q[l] && !ovf_q[l] && !full_pre[l];
        end
    end

`ifdef JESD_DL_CHAR_REPLACE_EN
    logic [FW-1:0] fcnt_q [LANES];
    logic [FW-1:0] fcnt_d [LANES];
    logic [7:0]    held_q [LANES];
    logic [7:0]    held_d [LANES];

    always_comb begin
        logic [FW-1:0] pos;
        logic [7:0]    oct;
        pos = '0;
        oct = '0;
        for (int l = 0; l < LANES; l++) begin
            pos         = start_now[l] ? '0 : fcnt_q[l];
            held_d[l]   = held_q[l];
            proc_dat[l] = in_data[l*W +: W];
            for (int o = 0; o < OCTETS_PER_CYC; o++) begin
                oct = in_data[(l*OCTETS_PER_CYC+o)*8 +: 8];
                if (pos == FW'(F-1)) begin
                    if (!scramble_en && in_charisk[l*OCTETS_PER_CYC+o] &&
                        (oct == 8'h7C || oct == 8'hFC))
                        oct = held_d[l];
                    if (wr_req[l]) held_d[l] = oct;
                end
                proc_dat[l][o*8 +: 8] = oct;
                pos = (pos == FW'(F-1)) ? '0 : pos + 1'b1;
            end
            fcnt_d[l] = clear ? '0 : (wr_req[l] ? pos : fcnt_q[l]);
        end
    end

    always_ff @(posedge clk) begin
        for (int l = 0; l < LANES; l++) begin
            if (reset) begin
                fcnt_q[l] <= '0;
                held_q[l] <= 8'h00;
            end else begin
                fcnt_q[l] <= fcnt_d[l];
                held_q[l] <= held_d[l];
            end
        end
    end
`else
    always_comb begin
        for (int l = 0; l < LANES; l++) proc_dat[l] = in_data[l*W +: W];
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int l = 0; l < LANES; l++) begin
                state_q[l]  <= CGS_INIT;
                vcnt_q[l]   <= 2'd0;
                icnt_q[l]   <= 2'd0;
                s1_dat_q[l] <= '0;
                wr_ptr_q[l] <= '0;
            end
            s1_wen_q    <= '0;
            started_q   <= '0;
            ovf_q       <= '0;
            buf_err_q   <= '0;
            rd_ptr_q    <= '0;
            release_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '1;
            sync_n_q    <= 1'b0;
        end else begin
            sync_n_q  <= ~|init_d;
            buf_err_q <= buf_err_q | full_pre;
            s1_wen_q  <= wr_req;
            for (int l = 0; l < LANES; l++) begin
                state_q[l]  <= state_d[l];
                vcnt_q[l]   <= vcnt_d[l];
                icnt_q[l]   <= icnt_d[l];
                s1_dat_q[l] <= proc_dat[l];
            end
            if (clear) begin
                for (int l = 0; l < LANES; l++) wr_ptr_q[l] <= '0;
                started_q   <= '0;
                ovf_q       <= '0;
                rd_ptr_q    <= '0;
                release_q   <= 1'b0;
                out_valid_q <= 1'b0;
            end else begin
                for (int l = 0; l < LANES; l++)
                    if (wr_go[l]) wr_ptr_q[l] <= wr_ptr_q[l] + 1'b1;
                started_q   <= started_q | start_now;
                ovf_q       <= ovf_q | full_pre;
                // started_q lags start by a clk, so an lmfc on the last start cycle is ignored.
                release_q   <= release_q | (&started_q & lmfc);
                out_valid_q <= release_q;
                if (release_q) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                    for (int l = 0; l < LANES; l++)
                        out_data_q[l*W +: W] <= mem_q[l][rd_ptr_q];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int l = 0; l < LANES; l++)
            if (!reset && !clear && wr_go[l]) mem_q[l][wr_ptr_q[l]] <= s1_dat_q[l];
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign sync_n    = sync_n_q;
    assign buf_err   = buf_err_q;

endmodule

// File: tb/tb_jesd204b_dl_rx_mlane.sv
// Directed bench for jesd204b_dl_rx_mlane: CGS table plus alignment, overflow, resync and replacement sequences.
module tb_jesd204b_dl_rx_mlane;
    logic        clk = 1'b0;
    logic        reset, lmfc, scramble_en;
    logic [63:0] in_data;
    logic [7:0]  in_charisk;
    logic [1:0]  in_valid;
    logic [63:0] out_data;
    logic        out_valid, sync_n;
    logic [1:0]  buf_err;
    int          checks = 0;
    int          errors = 0;

    jesd204b_dl_rx_mlane #(
        .LANES(2), .OCTETS_PER_CYC(4), .F(5), .K(4), .BUF_DEPTH(32)
    ) dut (
        .clk(clk), .reset(reset), .lmfc(lmfc), .scramble_en(scramble_en),
        .in_data(in_data), .in_charisk(in_charisk), .in_valid(in_valid),
        .out_data(out_data), .out_valid(out_valid), .sync_n(sync_n), .buf_err(buf_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] vld;
        logic       lmfc;
        logic       exp_sync;
        logic       exp_ovld;
    } cgs_vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic set_lane(input int l, input logic [31:0] d, input logic [3:0] ck);
        in_data[l*32 +: 32]  = d;
        in_charisk[l*4 +: 4] = ck;
    endtask

    task automatic set_k(input int l);
        set_lane(l, 32'hBCBCBCBC, 4'hF);
    endtask

    function automatic logic [31:0] dw(input int l, input int i);
        return {8'(8'hA0 + l), 8'(i), 8'(i*3), 8'(i+7)};
    endfunction

    initial begin
        cgs_vec_t    tbl [15];
        logic [31:0] cw [5];
        logic [3:0]  ck [5];
        logic [31:0] ex [5];

        reset = 1'b1; lmfc = 1'b0; scramble_en = 1'b0; in_valid = 2'b00;
        set_k(0); set_k(1);
        tick(); tick();
        chk("rst_sync_n", {63'd0, sync_n}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_data", out_data, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("rst_buf_err", {62'd0, buf_err}, 64'd0);
        reset = 1'b0;

        // Both lanes send /K/ throughout; only in_valid and lmfc vary.
        tbl[0]  = '{2'b01, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{2'b01, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{2'b11, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{2'b11, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{2'b01, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{2'b01, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{2'b11, 1'b1, 1'b1, 1'b0};
        tbl[7]  = '{2'b01, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{2'b01, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{2'b01, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{2'b11, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{2'b11, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{2'b11, 1'b0, 1'b1, 1'b0};
        tbl[13] = '{2'b11, 1'b0, 1'b1, 1'b0};
        tbl[14] = '{2'b11, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 15; i++) begin
            in_valid = tbl[i].vld;
            lmfc     = tbl[i].lmfc;
            tick();
            chk($sformatf("cgs%0d_sync_n", i), {63'd0, sync_n}, {63'd0, tbl[i].exp_sync});
            chk($sformatf("cgs%0d_out_valid", i), {63'd0, out_valid}, {63'd0, tbl[i].exp_ovld});
        end
        lmfc = 1'b0;

        // Lane0 streams with no lmfc and lane1 never starts: lane0 overflows.
        set_lane(0, dw(0, 0), 4'h0);
        tick();
        for (int i = 1; i < 32; i++) begin
            set_lane(0, dw(0, i), 4'h0);
            tick();
        end
        chk("ovf_before", {62'd0, buf_err}, 64'd0);
        set_lane(0, dw(0, 32), 4'h0);
        tick();
        chk("ovf_set", {62'd0, buf_err}, 64'd1);
        lmfc = 1'b1;
        for (int i = 0; i < 2; i++) begin
            set_lane(0, dw(0, 33 + i), 4'h0);
            tick();
            chk($sformatf("ovf_no_release%0d", i), {63'd0, out_valid}, 64'd0);
        end
        lmfc = 1'b0;

        in_valid = 2'b10;
        set_k(0);
        repeat (3) tick();
        chk("resync_sync_n", {63'd0, sync_n}, 64'd0);
        chk("resync_buf_err", {62'd0, buf_err}, 64'd1);
        in_valid = 2'b11;
        repeat (5) tick();
        chk("relock_sync_n", {63'd0, sync_n}, 64'd1);

        // Lane1 starts 3 clk after lane0; lmfc on lane1's start cycle must not release.
        for (int c = 0; c < 11; c++) begin
            set_lane(0, dw(0, c), 4'h0);
            if (c >= 3) set_lane(1, dw(1, c - 3), 4'h0);
            else        set_k(1);
            lmfc = (c == 3 || c == 6);
            tick();
            if (c >= 3 && c <= 6)
                chk($sformatf("align_hold%0d", c), {63'd0, out_valid}, 64'd0);
            if (c >= 7) begin
                chk($sformatf("align_valid%0d", c), {63'd0, out_valid}, 64'd1);
                chk($sformatf("align_data%0d", c), out_data, {dw(1, c - 7), dw(0, c - 7)});
            end
        end
        lmfc = 1'b0;

        // Lane0 loses valid for 3 clk after release.
        in_valid = 2'b10;
        set_k(0);
        for (int i = 0; i < 3; i++) begin
            set_lane(1, dw(1, 8 + i), 4'h0);
            tick();
            chk($sformatf("drop_out_valid%0d", i), {63'd0, out_valid}, {63'd0, (i < 2)});
        end
        chk("drop_sync_n", {63'd0, sync_n}, 64'd0);
        chk("drop_buf_err", {62'd0, buf_err}, 64'd1);

        // Frame-end alignment characters on lane0 (F=5, 4 octets/clk).
        in_valid = 2'b11;
        set_k(0); set_k(1);
        repeat (5) tick();
        cw[0] = 32'h13121110; ck[0] = 4'b0000;
        cw[1] = 32'h2322215A; ck[1] = 4'b0000;
        cw[2] = 32'h33327C30; ck[2] = 4'b0010;
        cw[3] = 32'h43FC4140; ck[3] = 4'b0100;
        cw[4] = 32'h7C525150; ck[4] = 4'b1000;
        for (int i = 0; i < 5; i++) ex[i] = cw[i];
`ifdef JESD_DL_CHAR_REPLACE_EN
        ex[2] = 32'h33325A30;
        ex[3] = 32'h435A4140;
`endif
        for (int c = 0; c < 8; c++) begin
            if (c < 5) set_lane(0, cw[c], ck[c]);
            else       set_lane(0, dw(0, 50 + c), 4'h0);
            set_lane(1, dw(1, 40 + c), 4'h0);
            scramble_en = (c == 4);
            lmfc        = (c == 1);
            tick();
            if (c >= 2 && c <= 6) begin
                chk($sformatf("repl_valid%0d", c), {63'd0, out_valid}, 64'd1);
                chk($sformatf("repl_data%0d", c), out_data, {dw(1, 40 + c - 2), ex[c - 2]});
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/jesd204b_dl_rx_mlane.md
JESD204B_DL_RX_MLANE -- requirements
Module: jesd204b_dl_rx_mlane

Interface
REQ-001 SHALL have parameter LANES, default 2, number of serial lanes.
REQ-002 SHALL have parameter OCTETS_PER_CYC, default 4, octets per lane per clk.
REQ-003 SHALL have parameter F, default 5, octets per frame; K, default 4, frames per multiframe.
REQ-004 SHALL have parameter BUF_DEPTH, default 32, elastic buffer words per lane (power of 2).
REQ-005 SHALL have port clk  in  1  rising-edge clock.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port lmfc  in  1  single-cycle local multiframe clock pulse.
REQ-008 SHALL have port scramble_en  in  1  scrambling enabled on link.
REQ-009 SHALL have port in_data  in  LANES*8*OCTETS_PER_CYC  lane words, lane 0 in LSBs, octet 0 in LSBs.
REQ-010 SHALL have port in_charisk  in  LANES*OCTETS_PER_CYC  per-octet K-character flag.
REQ-011 SHALL have port in_valid  in  LANES  per-lane word free of disparity/not-in-table error.
REQ-012 SHALL have port out_data  out  LANES*8*OCTETS_PER_CYC  lane-aligned data.
REQ-013 SHALL have port out_valid  out  1  out_data is aligned user/ILAS data.
REQ-014 SHALL have ports sync_n  out  1  active-low SYNC request; buf_err  out  LANES  sticky per-lane overflow flag.

Function
REQ-015 Each lane SHALL run an FSM: CGS_INIT, CGS_CHECK, CGS_DATA.
REQ-016 CGS_INIT -> CGS_CHECK when in_valid=1 and every octet equals 0xBC with charisk=1.
REQ-017 CGS_CHECK -> CGS_INIT after 3 consecutive invalid cycles; -> CGS_DATA after 4 consecutive valid cycles; invalid-run and valid-run counters clear each other.
REQ-018 CGS_DATA -> CGS_CHECK on any in_valid=0 cycle.
REQ-019 sync_n SHALL be registered, 0 while any lane is in CGS_INIT, else 1.
REQ-020 A lane SHALL mark "started" on the first cycle outside CGS_INIT whose word is not all /K/; from that word its frame octet counter counts modulo F and its words are written to its buffer, one per clk.
REQ-021 When all lanes are started, the first lmfc pulse SHALL assert release; thereafter all buffers are read together every clk.
REQ-022 out_valid SHALL rise 1 clk after release; out_data SHALL be the buffer read word registered (1 clk read latency).
REQ-023 Input-to-buffer write path SHALL be 1 registered stage.
REQ-024 If a lane's fill level reaches BUF_DEPTH-1 before release, its buf_err bit SHALL set and further writes to that lane SHALL be dropped.
REQ-025 Any lane re-entering CGS_INIT SHALL clear all started flags, release, out_valid and all buffer pointers in the same cycle; buf_err stays.
REQ-026 lmfc coinciding with the last lane start SHALL NOT release; the next lmfc SHALL.
REQ-027 Pointer arithmetic SHALL be log2(BUF_DEPTH) bits with natural wrap-around.

Reset
REQ-028 On reset: all FSMs CGS_INIT, sync_n=0, out_valid=0, out_data all 0xFF, buf_err=0, pointers, counters, started flags and release cleared.
REQ-029 Reset SHALL take precedence over every other event in the same cycle.

Configuration
REQ-030 Macro JESD_DL_CHAR_REPLACE_EN SHALL enable alignment character replacement; undefined, octets pass to buffers unchanged.
REQ-031 With it, scramble_en=0: K octet 0x7C or 0xFC at frame-end position SHALL be replaced with the held output octet of the previous frame end; held value updates at every frame end with the output octet.
REQ-032 With it, scramble_en=1: such K octets SHALL be output as data 0x7C/0xFC, held value not used.

Verification
REQ-033 Reset, lane0 all-/K/ valid, lane1 invalid -> sync_n stays 0; lane1 all-/K/ -> sync_n=1 next clk.
REQ-034 Lane in CGS_CHECK, 3 invalid cycles -> CGS_INIT, sync_n=0; 2 invalid then 1 valid -> stays CGS_CHECK.
REQ-035 Lane1 starts 3 clk after lane0, lmfc after both -> out_valid 1 clk after lmfc, lane0/lane1 first ILAS words on same cycle.
REQ-036 Macro defined, scramble_en=0, frame ends 0x5A then /A/ 0x7C -> output 0x5A; again /F/ -> 0x5A.
REQ-037 No lmfc for 31 clk after lane0 start -> buf_err[0]=1, writes stop, other lanes unaffected.
REQ-038 Post-release, lane0 in_valid=0 for 3 clk -> out_valid=0 and pointers cleared, buf_err unchanged.
